// File: rtl/dual_cam_i2c_pkg.sv
// Shared definitions for the dual-camera I2C arbiter.
//   arb_state_t : arbiter FSM states, in transaction order.
//   REQ_CAM0/1  : requester indices, used for the grant, pending, done and error bits.
package dual_cam_i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_ISSUE,
    ST_WAIT,
    ST_RELEASE
  } arb_state_t;

  localparam int unsigned REQ_CAM0 = 0;
  localparam int unsigned REQ_CAM1 = 1;

endpackage

// File: rtl/i2c_req_latch.sv
// Request latch for one camera config sequencer.
// A single exec pulse sets the pending flag and captures the payload.
// A clear from the arbiter drops the pending flag.
// An exec while the flag is already set keeps the old payload and raises drop for one cycle.
// An exec in the same cycle as a clear wins over the clear and captures the new payload.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   exec     : request pulse
//   data     : request payload, captured on exec
//   clr      : release of this requester by the arbiter
//   pending  : request waiting for service
//   data_q   : captured payload
//   drop     : one-cycle flag, exec ignored because a request was already pending
module i2c_req_latch #(
  parameter int unsigned DW = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          exec,
  input  logic [DW-1:0] data,
  input  logic          clr,
  output logic          pending,
  output logic [DW-1:0] data_q,
  output logic          drop
);

  assign drop = exec & pending & ~clr;

  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= 1'b0;
      data_q  <= '0;
    end else if (exec && (!pending || clr)) begin
      pending <= 1'b1;
      data_q  <= data;
    end else if (clr) begin
      pending <= 1'b0;
    end
  end

endmodule

// File: rtl/dual_cam_i2c_arbiter.sv
// Shares one I2C master between the two OV5640 config sequencers.
// Both cameras answer at the same slave address, so bus_sel steers SCL/SDA to the owner.
// Sequence: IDLE -> SELECT (settle GAP_CYC) -> ISSUE (m_exec) -> WAIT (m_done/timeout) -> RELEASE.
// Ports:
//   clk, rst            : I2C driver clock, synchronous active-high reset
//   reqN_exec/reqN_data : camera N request pulse and {addr16,data8} payload
//   reqN_done           : one-cycle completion (or timeout) pulse to camera N
//   m_exec/m_data       : start pulse and payload to the I2C driver
//   m_done              : driver completion pulse (ignored outside WAIT)
//   bus_sel             : 0 = cam0 bus, 1 = cam1 bus
//   err_timeout         : sticky per requester, WAIT exceeded TIMEOUT_CYC
//   err_drop            : sticky per requester, exec while already pending
//   stat_cnt0/1         : completed transactions per requester
// Build option: I2C_ARB_STATS_EN builds the stat counters; otherwise they are tied to zero.
module dual_cam_i2c_arbiter
  import dual_cam_i2c_pkg::*;
#(
  parameter int unsigned DW          = 24,
  parameter logic [7:0]  GAP_CYC     = 8'd4,
  parameter logic [19:0] TIMEOUT_CYC = 20'd500000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_exec,
  input  logic [DW-1:0] req0_data,
  output logic          req0_done,
  input  logic          req1_exec,
  input  logic [DW-1:0] req1_data,
  output logic          req1_done,
  output logic          m_exec,
  output logic [DW-1:0] m_data,
  input  logic          m_done,
  output logic          bus_sel,
  output logic [1:0]    err_timeout,
  output logic [1:0]    err_drop,
  output logic [15:0]   stat_cnt0,
  output logic [15:0]   stat_cnt1
);

  arb_state_t    state, state_next;
  logic [19:0]   cnt, cnt_next;
  logic          grant;
  logic          rr_ptr;
  logic          pick;
  logic          load;
  logic          tmo_hit;
  logic [1:0]    pending;
  logic [1:0]    drop;
  logic [1:0]    clr;
  logic [DW-1:0] data_q0, data_q1;

  i2c_req_latch #(.DW(DW)) u_latch0 (
    .clk     (clk),
    .rst     (rst),
    .exec    (req0_exec),
    .data    (req0_data),
    .clr     (clr[REQ_CAM0]),
    .pending (pending[REQ_CAM0]),
    .data_q  (data_q0),
    .drop    (drop[REQ_CAM0])
  );

  i2c_req_latch #(.DW(DW)) u_latch1 (
    .clk     (clk),
    .rst     (rst),
    .exec    (req1_exec),
    .data    (req1_data),
    .clr     (clr[REQ_CAM1]),
    .pending (pending[REQ_CAM1]),
    .data_q  (data_q1),
    .drop    (drop[REQ_CAM1])
  );

  // One counter serves both the SELECT settle time and the WAIT timeout.
  // SELECT counts 0..GAP_CYC, so m_exec lands GAP_CYC+2 cycles after the request edge.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    load       = 1'b0;
    pick       = grant;
    tmo_hit    = 1'b0;
    m_exec     = 1'b0;
    req0_done  = 1'b0;
    req1_done  = 1'b0;
    clr        = '0;
    case (state)
      ST_IDLE: begin
        if (|pending) begin
          load       = 1'b1;
          // rr_ptr holds the requester that wins a tie; otherwise the sole pending one wins.
          pick       = (pending == 2'b11) ? rr_ptr : pending[REQ_CAM1];
          cnt_next   = '0;
          state_next = ST_SELECT;
        end
      end
      ST_SELECT: begin
        if (cnt == {12'd0, GAP_CYC}) begin
          state_next = ST_ISSUE;
        end else begin
          cnt_next = cnt + 20'd1;
        end
      end
      ST_ISSUE: begin
        m_exec     = 1'b1;
        cnt_next   = '0;
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (m_done) begin
          state_next = ST_RELEASE;
        end else if (cnt == TIMEOUT_CYC - 20'd1) begin
          tmo_hit    = 1'b1;
          state_next = ST_RELEASE;
        end else begin
          cnt_next = cnt + 20'd1;
        end
      end
      ST_RELEASE: begin
        req0_done  = ~grant;
        req1_done  = grant;
        clr[grant] = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      grant       <= 1'b0;
      rr_ptr      <= 1'b0;
      bus_sel     <= 1'b0;
      m_data      <= '0;
      err_timeout <= '0;
      err_drop    <= '0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      err_drop <= err_drop | drop;
      if (load) begin
        grant   <= pick;
        bus_sel <= pick;
        m_data  <= pick ? data_q1 : data_q0;
      end
      if (tmo_hit) begin
        err_timeout[grant] <= 1'b1;
      end
      if (state == ST_RELEASE) begin
        rr_ptr <= ~grant;
      end
    end
  end

`ifdef I2C_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_cnt0 <= '0;
      stat_cnt1 <= '0;
    end else if (state == ST_RELEASE) begin
      if (grant) begin
        stat_cnt1 <= stat_cnt1 + 16'd1;
      end else begin
        stat_cnt0 <= stat_cnt0 + 16'd1;
      end
    end
  end
`else
  assign stat_cnt0 = '0;
  assign stat_cnt1 = '0;
`endif

endmodule
